// File: rtl/memory_layer_input_sequencer_pkg.sv
// Shared types for the memory-layer input sequencer: pattern vector, class label,
// sequencer FSM states and the FIFO entry layout.
package memory_layer_input_sequencer_pkg;

    localparam int unsigned NODE_W  = 8;
    localparam int unsigned N_NODES = 4;

    typedef logic [N_NODES-1:0][NODE_W-1:0] node_vector_T;

    // Class label, matches the memory-layer c input.
    typedef int class_T;

    localparam int unsigned X_W = $bits(node_vector_T);
    localparam int unsigned C_W = $bits(class_T);

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_START,
        SEQ_BUSY,
        SEQ_DONE
    } seq_state_T;

    // One buffered training pattern.
    typedef struct packed {
        node_vector_T x;
        class_T       c;
        logic         last;
    } seq_entry_t;

    // A pattern opens a new class when nothing was issued before or the label differs.
    function automatic logic class_changed(input logic prev_valid, input class_T prev_c,
                                           input class_T c);
        return !prev_valid || (c != prev_c);
    endfunction

endpackage

// File: rtl/gam_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, combinational head read.
// Ports: clk, rst_n (async active-low), clr (sync clear, beats push/pop),
//        push/din, pop/dout (head), count (occupancy), empty.
// A full FIFO refuses a push even when a pop happens in the same cycle.
module gam_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  T                         din,
    input  logic                     pop,
    output T                         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !clr;
    assign pop_ok  = pop && !empty && !clr;
    assign dout    = mem[rd_ptr];

    // Storage array, no reset needed: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/memory_layer_input_sequencer.sv
// Upstream feeder for the GAM memory layer. Buffers {x, c, last} patterns, issues them
// one at a time with a start_o pulse, waits for done_i, tracks class changes, counts
// completed patterns and latches learning_done_o after the last pattern completes.
// Ports: clk, rst_n (async active-low), flush (sync clear, highest priority),
//        in_valid/in_ready/in_x/in_c/in_last (input stream),
//        x_o/c_o/new_class_o/start_o (issued pattern), done_i (memory layer done),
//        learning_done_o, pattern_count_o, fifo_count_o (status).
module memory_layer_input_sequencer
    import memory_layer_input_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [X_W-1:0]             in_x,
    input  logic [C_W-1:0]             in_c,
    input  logic                       in_last,
    output logic [X_W-1:0]             x_o,
    output logic [C_W-1:0]             c_o,
    output logic                       new_class_o,
    output logic                       start_o,
    input  logic                       done_i,
    output logic                       learning_done_o,
    output logic [CNT_W-1:0]           pattern_count_o,
    output logic [$clog2(DEPTH):0]     fifo_count_o
);

    localparam int unsigned FC_W = $clog2(DEPTH) + 1;

    seq_state_T           state;
    seq_state_T           state_nxt;
    seq_entry_t           push_entry;
    seq_entry_t           head;
    logic                 fifo_empty;
    logic [FC_W-1:0]      fifo_count;
    logic                 push;
    logic                 pop;

    logic                 last_r;
    class_T               prev_c;
    logic                 prev_valid;

    logic [X_W-1:0]       x_nxt;
    logic [C_W-1:0]       c_nxt;
    logic                 new_class_nxt;
    logic                 start_nxt;
    logic                 learning_done_nxt;
    logic [CNT_W-1:0]     count_nxt;
    logic                 last_nxt;
    class_T               prev_c_nxt;
    logic                 prev_valid_nxt;

    assign fifo_count_o = fifo_count;
    assign in_ready     = (fifo_count < FC_W'(DEPTH)) && (state != SEQ_DONE) && !flush;
    assign push         = in_valid && in_ready;

    assign push_entry.x    = node_vector_T'(in_x);
    assign push_entry.c    = class_T'(in_c);
    assign push_entry.last = in_last;

    gam_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (seq_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, pop request and next values of the registered outputs.
    always_comb begin
        state_nxt         = state;
        pop               = 1'b0;
        x_nxt             = x_o;
        c_nxt             = c_o;
        new_class_nxt     = new_class_o;
        start_nxt         = 1'b0;
        learning_done_nxt = learning_done_o;
        count_nxt         = pattern_count_o;
        last_nxt          = last_r;
        prev_c_nxt        = prev_c;
        prev_valid_nxt    = prev_valid;

        if (flush) begin
            state_nxt         = SEQ_IDLE;
            x_nxt             = '0;
            c_nxt             = '0;
            new_class_nxt     = 1'b0;
            learning_done_nxt = 1'b0;
            count_nxt         = '0;
            last_nxt          = 1'b0;
            prev_c_nxt        = '0;
            prev_valid_nxt    = 1'b0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (!fifo_empty) begin
                        pop            = 1'b1;
                        x_nxt          = X_W'(head.x);
                        c_nxt          = C_W'(head.c);
                        last_nxt       = head.last;
                        new_class_nxt  = class_changed(prev_valid, prev_c, head.c);
                        prev_c_nxt     = head.c;
                        prev_valid_nxt = 1'b1;
                        start_nxt      = 1'b1;
                        state_nxt      = SEQ_START;
                    end
                end
                // done_i during the start pulse is deliberately not sampled.
                SEQ_START: begin
                    state_nxt = SEQ_BUSY;
                end
                SEQ_BUSY: begin
                    if (done_i) begin
                        if (pattern_count_o != '1) begin
                            count_nxt = pattern_count_o + CNT_W'(1);
                        end
                        if (last_r) begin
                            learning_done_nxt = 1'b1;
                            state_nxt         = SEQ_DONE;
                        end else begin
                            state_nxt = SEQ_IDLE;
                        end
                    end
                end
                SEQ_DONE: begin
                    state_nxt = SEQ_DONE;
                end
                default: begin
                    state_nxt = SEQ_IDLE;
                end
            endcase
        end
    end

    // Registered outputs and class tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_o             <= '0;
            c_o             <= '0;
            new_class_o     <= 1'b0;
            start_o         <= 1'b0;
            learning_done_o <= 1'b0;
            pattern_count_o <= '0;
            last_r          <= 1'b0;
            prev_c          <= '0;
            prev_valid      <= 1'b0;
        end else begin
            x_o             <= x_nxt;
            c_o             <= c_nxt;
            new_class_o     <= new_class_nxt;
            start_o         <= start_nxt;
            learning_done_o <= learning_done_nxt;
            pattern_count_o <= count_nxt;
            last_r          <= last_nxt;
            prev_c          <= prev_c_nxt;
            prev_valid      <= prev_valid_nxt;
        end
    end

endmodule

// File: tb/tb_memory_layer_input_sequencer.sv
// Directed bench for memory_layer_input_sequencer: a cycle table for the basic flow
// plus hand-written sequences for back-pressure, the last pattern and async reset.
module tb_memory_layer_input_sequencer;
    import memory_layer_input_sequencer_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned FC_W  = $clog2(DEPTH) + 1;
    localparam int unsigned NV    = 22;

    localparam logic [X_W-1:0] XA = X_W'(32'hA0A1_A2A3);
    localparam logic [X_W-1:0] XB = X_W'(32'hB0B1_B2B3);
    localparam logic [X_W-1:0] XC = X_W'(32'hC0C1_C2C3);
    localparam logic [X_W-1:0] XD = X_W'(32'hD0D1_D2D3);
    localparam logic [X_W-1:0] XE = X_W'(32'hE0E1_E2E3);
    localparam logic [X_W-1:0] XZ = '0;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [X_W-1:0]   in_x;
    logic [C_W-1:0]   in_c;
    logic             in_last;
    logic [X_W-1:0]   x_o;
    logic [C_W-1:0]   c_o;
    logic             new_class_o;
    logic             start_o;
    logic             done_i;
    logic             learning_done_o;
    logic [CNT_W-1:0] pattern_count_o;
    logic [FC_W-1:0]  fifo_count_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic             fl;
        logic             v;
        logic [X_W-1:0]   x;
        logic [C_W-1:0]   c;
        logic             last;
        logic             done;
        logic             rdy;
        logic             st;
        logic             nc;
        logic [X_W-1:0]   xo;
        logic [C_W-1:0]   co;
        logic             ld;
        logic [CNT_W-1:0] pc;
        logic [FC_W-1:0]  fc;
    } vec_t;

    vec_t vecs [NV];

    memory_layer_input_sequencer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_x            (in_x),
        .in_c            (in_c),
        .in_last         (in_last),
        .x_o             (x_o),
        .c_o             (c_o),
        .new_class_o     (new_class_o),
        .start_o         (start_o),
        .done_i          (done_i),
        .learning_done_o (learning_done_o),
        .pattern_count_o (pattern_count_o),
        .fifo_count_o    (fifo_count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic fl, input logic v, input logic [X_W-1:0] x,
                                input logic [C_W-1:0] c, input logic last, input logic done,
                                input logic rdy, input logic st, input logic nc,
                                input logic [X_W-1:0] xo, input logic [C_W-1:0] co,
                                input logic ld, input logic [CNT_W-1:0] pc,
                                input logic [FC_W-1:0] fc);
        vec_t r;
        r.fl = fl; r.v = v; r.x = x; r.c = c; r.last = last; r.done = done;
        r.rdy = rdy; r.st = st; r.nc = nc; r.xo = xo; r.co = co; r.ld = ld;
        r.pc = pc; r.fc = fc;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, sample in_ready before the rising
    // edge, then leave the registered outputs settled 1 ns after it.
    task automatic step(input logic fl, input logic v, input logic [X_W-1:0] x,
                        input logic [C_W-1:0] c, input logic last, input logic done,
                        output logic rdy);
        @(negedge clk);
        flush    = fl;
        in_valid = v;
        in_x     = x;
        in_c     = c;
        in_last  = last;
        done_i   = done;
        #1;
        rdy = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int budget, output logic seen);
        logic r;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            step(1'b0, 1'b0, XZ, '0, 1'b0, 1'b0, r);
            if (start_o) seen = 1'b1;
        end
    endtask

    initial begin
        logic rdy_s;
        logic seen;
        int   starts;

        // fl v  x   c    last done | rdy st nc xo  co  ld pc fc
        vecs[0]  = mk(0, 0, XZ, 32'd0, 0, 0, 1, 0, 0, XZ, 32'd0, 0, 16'd0, 3'd0);
        vecs[1]  = mk(0, 1, XA, 32'd3, 0, 0, 1, 0, 0, XZ, 32'd0, 0, 16'd0, 3'd1);
        vecs[2]  = mk(0, 0, XZ, 32'd0, 0, 0, 1, 1, 1, XA, 32'd3, 0, 16'd0, 3'd0);
        vecs[3]  = mk(0, 0, XZ, 32'd0, 0, 1, 1, 0, 1, XA, 32'd3, 0, 16'd0, 3'd0);
        vecs[4]  = mk(0, 0, XZ, 32'd0, 0, 0, 1, 0, 1, XA, 32'd3, 0, 16'd0, 3'd0);
        vecs[5]  = mk(0, 0, XZ, 32'd0, 0, 1, 1, 0, 1, XA, 32'd3, 0, 16'd1, 3'd0);
        vecs[6]  = mk(0, 0, XZ, 32'd0, 0, 1, 1, 0, 1, XA, 32'd3, 0, 16'd1, 3'd0);
        vecs[7]  = mk(1, 1, XE, 32'd9, 0, 1, 0, 0, 0, XZ, 32'd0, 0, 16'd0, 3'd0);
        vecs[8]  = mk(0, 1, XB, 32'd3, 0, 0, 1, 0, 0, XZ, 32'd0, 0, 16'd0, 3'd1);
        vecs[9]  = mk(0, 1, XC, 32'd3, 0, 0, 1, 1, 1, XB, 32'd3, 0, 16'd0, 3'd1);
        vecs[10] = mk(0, 1, XD, 32'd5, 0, 0, 1, 0, 1, XB, 32'd3, 0, 16'd0, 3'd2);
        vecs[11] = mk(0, 0, XZ, 32'd0, 0, 0, 1, 0, 1, XB, 32'd3, 0, 16'd0, 3'd2);
        vecs[12] = mk(0, 0, XZ, 32'd0, 0, 0, 1, 0, 1, XB, 32'd3, 0, 16'd0, 3'd2);
        vecs[13] = mk(0, 0, XZ, 32'd0, 0, 0, 1, 0, 1, XB, 32'd3, 0, 16'd0, 3'd2);
        vecs[14] = mk(0, 0, XZ, 32'd0, 0, 1, 1, 0, 1, XB, 32'd3, 0, 16'd1, 3'd2);
        vecs[15] = mk(0, 0, XZ, 32'd0, 0, 0, 1, 1, 0, XC, 32'd3, 0, 16'd1, 3'd1);
        vecs[16] = mk(0, 0, XZ, 32'd0, 0, 0, 1, 0, 0, XC, 32'd3, 0, 16'd1, 3'd1);
        vecs[17] = mk(0, 0, XZ, 32'd0, 0, 1, 1, 0, 0, XC, 32'd3, 0, 16'd2, 3'd1);
        vecs[18] = mk(0, 0, XZ, 32'd0, 0, 0, 1, 1, 1, XD, 32'd5, 0, 16'd2, 3'd0);
        vecs[19] = mk(0, 0, XZ, 32'd0, 0, 0, 1, 0, 1, XD, 32'd5, 0, 16'd2, 3'd0);
        vecs[20] = mk(0, 0, XZ, 32'd0, 0, 1, 1, 0, 1, XD, 32'd5, 0, 16'd3, 3'd0);
        vecs[21] = mk(0, 0, XZ, 32'd0, 0, 1, 1, 0, 1, XD, 32'd5, 0, 16'd3, 3'd0);

        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_x     = '0;
        in_c     = '0;
        in_last  = 1'b0;
        done_i   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: first issue, ignored done_i, flush, class tracking and counting.
        for (int i = 0; i < int'(NV); i++) begin
            step(vecs[i].fl, vecs[i].v, vecs[i].x, vecs[i].c, vecs[i].last, vecs[i].done,
                 rdy_s);
            check($sformatf("v%0d_in_ready", i), 64'(rdy_s), 64'(vecs[i].rdy));
            check($sformatf("v%0d_start", i), 64'(start_o), 64'(vecs[i].st));
            check($sformatf("v%0d_new_class", i), 64'(new_class_o), 64'(vecs[i].nc));
            check($sformatf("v%0d_x", i), 64'(x_o), 64'(vecs[i].xo));
            check($sformatf("v%0d_c", i), 64'(c_o), 64'(vecs[i].co));
            check($sformatf("v%0d_learn_done", i), 64'(learning_done_o), 64'(vecs[i].ld));
            check($sformatf("v%0d_pat_count", i), 64'(pattern_count_o), 64'(vecs[i].pc));
            check($sformatf("v%0d_fifo_count", i), 64'(fifo_count_o), 64'(vecs[i].fc));
        end

        // Back-pressure: one pattern is popped into BUSY, the rest fill the FIFO.
        step(1'b1, 1'b0, XZ, '0, 1'b0, 1'b0, rdy_s);
        check("bp_flush_count", 64'(fifo_count_o), 64'd0);
        for (int i = 1; i <= int'(DEPTH) + 1; i++) begin
            step(1'b0, 1'b1, X_W'(i), C_W'(20 + i), 1'b0, 1'b0, rdy_s);
            check($sformatf("bp_push%0d_ready", i), 64'(rdy_s), 64'd1);
            check($sformatf("bp_push%0d_count", i), 64'(fifo_count_o),
                  (i == 1) ? 64'd1 : 64'(i - 1));
        end
        check("bp_full_ready", 64'(in_ready), 64'd0);
        step(1'b0, 1'b1, XE, 32'd99, 1'b0, 1'b0, rdy_s);
        check("bp_refused_ready", 64'(rdy_s), 64'd0);
        check("bp_refused_count", 64'(fifo_count_o), 64'(DEPTH));
        check("bp_busy_c", 64'(c_o), 64'd21);

        // Last pattern: learning_done latches, input is blocked until flush.
        step(1'b1, 1'b0, XZ, '0, 1'b0, 1'b0, rdy_s);
        step(1'b0, 1'b1, XE, 32'd7, 1'b1, 1'b0, rdy_s);
        wait_start(10, seen);
        check("last_start_seen", 64'(seen), 64'd1);
        check("last_c", 64'(c_o), 64'd7);
        step(1'b0, 1'b0, XZ, '0, 1'b0, 1'b0, rdy_s);
        check("last_busy_no_done", 64'(learning_done_o), 64'd0);
        step(1'b0, 1'b0, XZ, '0, 1'b0, 1'b1, rdy_s);
        check("last_learn_done", 64'(learning_done_o), 64'd1);
        check("last_pat_count", 64'(pattern_count_o), 64'd1);
        check("last_ready_low", 64'(in_ready), 64'd0);
        step(1'b0, 1'b1, XA, 32'd8, 1'b0, 1'b0, rdy_s);
        check("last_push_refused", 64'(rdy_s), 64'd0);
        check("last_push_count", 64'(fifo_count_o), 64'd0);
        step(1'b0, 1'b0, XZ, '0, 1'b0, 1'b1, rdy_s);
        check("last_done_hold", 64'(pattern_count_o), 64'd1);
        check("last_sticky", 64'(learning_done_o), 64'd1);
        step(1'b1, 1'b0, XZ, '0, 1'b0, 1'b0, rdy_s);
        check("flush_learn_done", 64'(learning_done_o), 64'd0);
        check("flush_pat_count", 64'(pattern_count_o), 64'd0);
        step(1'b0, 1'b0, XZ, '0, 1'b0, 1'b0, rdy_s);
        check("flush_ready", 64'(rdy_s), 64'd1);

        // Async reset mid-BUSY with three entries queued.
        step(1'b0, 1'b1, XA, 32'd2, 1'b0, 1'b0, rdy_s);
        wait_start(10, seen);
        check("rst_pre_start_seen", 64'(seen), 64'd1);
        step(1'b0, 1'b0, XZ, '0, 1'b0, 1'b0, rdy_s);
        step(1'b0, 1'b0, XZ, '0, 1'b0, 1'b1, rdy_s);
        check("rst_pre_count", 64'(pattern_count_o), 64'd1);
        for (int i = 1; i <= int'(DEPTH); i++) begin
            step(1'b0, 1'b1, X_W'(32'h100 + i), C_W'(10 + i), 1'b0, 1'b0, rdy_s);
        end
        check("rst_pre_fifo", 64'(fifo_count_o), 64'd3);
        check("rst_pre_c", 64'(c_o), 64'd11);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_fifo_count", 64'(fifo_count_o), 64'd0);
        check("rst_pat_count", 64'(pattern_count_o), 64'd0);
        check("rst_x", 64'(x_o), 64'd0);
        check("rst_c", 64'(c_o), 64'd0);
        check("rst_new_class", 64'(new_class_o), 64'd0);
        check("rst_start", 64'(start_o), 64'd0);
        check("rst_learn_done", 64'(learning_done_o), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        starts = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, XZ, '0, 1'b0, 1'b0, rdy_s);
            if (start_o) starts++;
        end
        check("rst_no_spurious_start", 64'(starts), 64'd0);
        check("rst_ready", 64'(rdy_s), 64'd1);
        step(1'b0, 1'b1, XB, 32'd11, 1'b0, 1'b0, rdy_s);
        wait_start(10, seen);
        check("rst_post_start_seen", 64'(seen), 64'd1);
        check("rst_post_new_class", 64'(new_class_o), 64'd1);
        check("rst_post_x", 64'(x_o), 64'(XB));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
